// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control FSM: state encodings,
// instruction classes, opcodes, immediate-format and next-PC/writeback codes.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd7
  } state_e;

  typedef enum logic [3:0] {
    CL_R, CL_IALU, CL_LOAD, CL_STORE, CL_BRANCH, CL_JAL, CL_JALR, CL_LUI, CL_AUIPC
  } class_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] IMM_I     = 3'b000;
  localparam logic [2:0] IMM_SHIFT = 3'b001;
  localparam logic [2:0] IMM_S     = 3'b010;
  localparam logic [2:0] IMM_U     = 3'b011;
  localparam logic [2:0] IMM_B     = 3'b100;
  localparam logic [2:0] IMM_J     = 3'b101;
  localparam logic [2:0] IMM_NONE  = 3'b111;

  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC4 = 2'b10;
  localparam logic [1:0] WD_IMM = 2'b11;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef struct packed {
    logic   legal;
    class_e cls;
  } dec_class_t;

  // Map an opcode to its instruction class; unknown opcodes are flagged illegal.
  function automatic dec_class_t classify(input logic [6:0] op);
    dec_class_t r;
    r.legal = 1'b1;
    r.cls   = CL_R;
    case (op)
      OP_R:      r.cls = CL_R;
      OP_IALU:   r.cls = CL_IALU;
      OP_LOAD:   r.cls = CL_LOAD;
      OP_STORE:  r.cls = CL_STORE;
      OP_BRANCH: r.cls = CL_BRANCH;
      OP_JAL:    r.cls = CL_JAL;
      OP_JALR:   r.cls = CL_JALR;
      OP_LUI:    r.cls = CL_LUI;
      OP_AUIPC:  r.cls = CL_AUIPC;
      default:   r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational decoder: instruction class + funct fields to immediate format,
// ALU operation and ALU operand selects.
module mc_ctrl_dec
  import mc_ctrl_pkg::*;
(
  input  class_e     cls_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7_5_i,
  output logic [2:0] sext_op_o,
  output logic [3:0] alu_op_o,
  output logic       alua_sel_o,
  output logic       alub_sel_o
);

  // Per-class control decode.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case leaves one unassigned (no latches).
    sext_op_o  = IMM_NONE;
    alu_op_o   = ALU_ADD;
    alua_sel_o = 1'b0;
    alub_sel_o = 1'b0;
    case (cls_i)
      CL_R:      alu_op_o = {funct7_5_i, funct3_i};
      CL_IALU: begin
        sext_op_o  = (funct3_i == 3'b001 || funct3_i == 3'b101) ? IMM_SHIFT : IMM_I;
        // Bit 30 only selects SRAI; for other I-ops it is immediate data.
        alu_op_o   = {funct7_5_i & (funct3_i == 3'b101), funct3_i};
        alub_sel_o = 1'b1;
      end
      CL_LOAD:   begin sext_op_o = IMM_I; alub_sel_o = 1'b1; end
      CL_STORE:  begin sext_op_o = IMM_S; alub_sel_o = 1'b1; end
      CL_BRANCH: begin sext_op_o = IMM_B; alu_op_o = ALU_SUB; end
      CL_JAL:    sext_op_o = IMM_J;
      CL_JALR:   begin sext_op_o = IMM_I; alub_sel_o = 1'b1; end
      CL_LUI:    begin sext_op_o = IMM_U; alub_sel_o = 1'b1; end
      CL_AUIPC:  begin sext_op_o = IMM_U; alua_sel_o = 1'b1; alub_sel_o = 1'b1; end
      default:   ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Optional MEM_TIMEOUT_EN: bound memory waits to TIMEOUT_CYC cycles, then TRAP.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       br_taken,
  output logic       imem_req,
  input  logic       imem_ack,
  output logic       dmem_req,
  output logic       dmem_we,
  input  logic       dmem_ack,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npc_op,
  output logic [2:0] sext_op,
  output logic [3:0] alu_op,
  output logic       alua_sel,
  output logic       alub_sel,
  output logic       rf_we,
  output logic [1:0] wd_sel,
  output logic       retire,
  output logic       trap,
  output logic [2:0] state_o
);

  state_e     state_q, state_d;
  class_e     class_q, class_d, cls_eff;
  dec_class_t dec;
  logic [2:0] dec_sext;
  logic       wait_expired;

  // IR is valid during DECODE, so the class decodes live there and is
  // registered for the rest of the instruction.
  assign dec     = classify(opcode);
  assign cls_eff = (state_q == ST_DECODE) ? dec.cls : class_q;
  assign class_d = (state_q == ST_DECODE) ? dec.cls : class_q;

  mc_ctrl_dec u_dec (
    .cls_i      (cls_eff),
    .funct3_i   (funct3),
    .funct7_5_i (funct7_5),
    .sext_op_o  (dec_sext),
    .alu_op_o   (alu_op),
    .alua_sel_o (alua_sel),
    .alub_sel_o (alub_sel)
  );

  assign sext_op = (state_q == ST_FETCH || state_q == ST_TRAP) ? IMM_NONE : dec_sext;
  assign trap    = (state_q == ST_TRAP);
  assign state_o = state_q;

  // Next-state logic and strobes; everything is held low while in reset.
  always_comb begin
    state_d  = state_q;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    rf_we    = 1'b0;
    retire   = 1'b0;
    npc_op   = NPC_PC4;
    wd_sel   = WD_ALU;
    if (rst_n) begin
      case (state_q)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_ack) begin
            ir_we   = 1'b1;
            state_d = ST_DECODE;
          end else if (wait_expired) begin
            state_d = ST_TRAP;
          end
        end
        ST_DECODE: state_d = dec.legal ? ST_EXEC : ST_TRAP;
        ST_EXEC: begin
          case (class_q)
            CL_BRANCH: begin
              pc_we   = 1'b1;
              npc_op  = br_taken ? NPC_BR : NPC_PC4;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end
            CL_LOAD, CL_STORE: state_d = ST_MEM;
            default:           state_d = ST_WB;
          endcase
        end
        ST_MEM: begin
          dmem_req = 1'b1;
          dmem_we  = (class_q == CL_STORE);
          if (dmem_ack) begin
            if (class_q == CL_STORE) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = ST_FETCH;
            end else begin
              state_d = ST_WB;
            end
          end else if (wait_expired) begin
            state_d = ST_TRAP;
          end
        end
        ST_WB: begin
          rf_we   = 1'b1;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = ST_FETCH;
          case (class_q)
            CL_JAL:  begin npc_op = NPC_JAL;  wd_sel = WD_PC4; end
            CL_JALR: begin npc_op = NPC_JALR; wd_sel = WD_PC4; end
            CL_LOAD: wd_sel = WD_MEM;
            CL_LUI:  wd_sel = WD_IMM;
            default: ;
          endcase
        end
        ST_TRAP: state_d = ST_TRAP;
        default: state_d = ST_TRAP;
      endcase
    end
  end

  // State and instruction-class registers.
  // NOTE: asynchronous active-low reset in the sensitivity list; the reset branch must come first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_FETCH;
      class_q <= CL_R;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      class_q <= class_d;
    end
  end

`ifdef MEM_TIMEOUT_EN
  logic [7:0] wait_q, wait_d;

  // Expire on the cycle the count would reach TIMEOUT_CYC.
  assign wait_expired = (wait_q == 8'(TIMEOUT_CYC - 1));

  // Wait counter: clears on any state change, counts unacknowledged req cycles.
  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q)
      wait_d = '0;
    else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack))
      wait_d = wait_q + 8'd1;
  end

  // Wait counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wait_q <= '0;
    else        wait_q <= wait_d;
  end
`else
  assign wait_expired = 1'b0;
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: table of single-instruction vectors with
// same-cycle acks, plus hand sequences for waits, traps, reset and timeout.
module tb_mc_ctrl;
  import mc_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5, br_taken, imem_ack, dmem_ack;
  logic       imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap;
  logic       alua_sel, alub_sel;
  logic [1:0] npc_op, wd_sel;
  logic [2:0] sext_op, state_o;
  logic [3:0] alu_op;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_ctrl #(.TIMEOUT_CYC(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .br_taken(br_taken), .imem_req(imem_req), .imem_ack(imem_ack), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_ack(dmem_ack), .ir_we(ir_we), .pc_we(pc_we), .npc_op(npc_op),
    .sext_op(sext_op), .alu_op(alu_op), .alua_sel(alua_sel), .alub_sel(alub_sel),
    .rf_we(rf_we), .wd_sel(wd_sel), .retire(retire), .trap(trap), .state_o(state_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       br;
    logic [2:0] sext;
    logic [3:0] alu;
    logic       alua;
    logic       alub;
    int         cycles;
    logic [1:0] npc;
    logic [1:0] wd;
    logic       rf;
  } vec_t;

  vec_t vecs[15];

  // Run one instruction from its FETCH cycle with same-cycle acks.
  task automatic run_vec(input vec_t v);
    int  pc_cnt = 0;
    int  rf_cnt = 0;
    bit  done   = 0;
    for (int cyc = 1; cyc <= 12 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        opcode = v.op; funct3 = v.f3; funct7_5 = v.f7; br_taken = v.br;
        imem_ack = 1'b1; dmem_ack = 1'b1;
      end
      #1;
      if (cyc == 1) check({v.name, ".fetch_state"}, state_o, 0);
      if (dmem_req) check({v.name, ".dmem_we"}, dmem_we, v.op == 7'b0100011);
      if (state_o == 3'd1) begin
        check({v.name, ".sext"}, sext_op, v.sext);
        check({v.name, ".alu"},  alu_op,  v.alu);
        check({v.name, ".alua"}, alua_sel, v.alua);
        check({v.name, ".alub"}, alub_sel, v.alub);
      end
      pc_cnt += int'(pc_we);
      rf_cnt += int'(rf_we);
      if (retire) begin
        check({v.name, ".latency"}, cyc, v.cycles);
        check({v.name, ".npc"}, npc_op, v.npc);
        check({v.name, ".wd"},  wd_sel, v.wd);
        done = 1;
      end
    end
    if (!done) check({v.name, ".retired"}, 0, 1);
    check({v.name, ".pc_we_count"}, pc_cnt, 1);
    check({v.name, ".rf_we_count"}, rf_cnt, v.rf);
  endtask

  initial begin
    logic [2:0] exp_trace [5];
    int req_cnt;
    bit done;

    vecs[0]  = '{"ADDI",     7'b0010011, 3'b000, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 4, 2'b00, 2'b00, 1'b1};
    vecs[1]  = '{"ADDI_B30", 7'b0010011, 3'b000, 1'b1, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 4, 2'b00, 2'b00, 1'b1};
    vecs[2]  = '{"SLLI",     7'b0010011, 3'b001, 1'b0, 1'b0, 3'b001, 4'b0001, 1'b0, 1'b1, 4, 2'b00, 2'b00, 1'b1};
    vecs[3]  = '{"SRAI",     7'b0010011, 3'b101, 1'b1, 1'b0, 3'b001, 4'b1101, 1'b0, 1'b1, 4, 2'b00, 2'b00, 1'b1};
    vecs[4]  = '{"ADD",      7'b0110011, 3'b000, 1'b0, 1'b0, 3'b111, 4'b0000, 1'b0, 1'b0, 4, 2'b00, 2'b00, 1'b1};
    vecs[5]  = '{"SUB",      7'b0110011, 3'b000, 1'b1, 1'b0, 3'b111, 4'b1000, 1'b0, 1'b0, 4, 2'b00, 2'b00, 1'b1};
    vecs[6]  = '{"SRA",      7'b0110011, 3'b101, 1'b1, 1'b0, 3'b111, 4'b1101, 1'b0, 1'b0, 4, 2'b00, 2'b00, 1'b1};
    vecs[7]  = '{"BEQ_T",    7'b1100011, 3'b000, 1'b0, 1'b1, 3'b100, 4'b1000, 1'b0, 1'b0, 3, 2'b01, 2'b00, 1'b0};
    vecs[8]  = '{"BEQ_NT",   7'b1100011, 3'b000, 1'b0, 1'b0, 3'b100, 4'b1000, 1'b0, 1'b0, 3, 2'b00, 2'b00, 1'b0};
    vecs[9]  = '{"LW",       7'b0000011, 3'b010, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 5, 2'b00, 2'b01, 1'b1};
    vecs[10] = '{"SW",       7'b0100011, 3'b010, 1'b0, 1'b0, 3'b010, 4'b0000, 1'b0, 1'b1, 4, 2'b00, 2'b00, 1'b0};
    vecs[11] = '{"JAL",      7'b1101111, 3'b000, 1'b0, 1'b0, 3'b101, 4'b0000, 1'b0, 1'b0, 4, 2'b10, 2'b10, 1'b1};
    vecs[12] = '{"JALR",     7'b1100111, 3'b000, 1'b0, 1'b0, 3'b000, 4'b0000, 1'b0, 1'b1, 4, 2'b11, 2'b10, 1'b1};
    vecs[13] = '{"LUI",      7'b0110111, 3'b000, 1'b0, 1'b0, 3'b011, 4'b0000, 1'b0, 1'b1, 4, 2'b00, 2'b11, 1'b1};
    vecs[14] = '{"AUIPC",    7'b0010111, 3'b000, 1'b0, 1'b0, 3'b011, 4'b0000, 1'b1, 1'b1, 4, 2'b00, 2'b00, 1'b1};

    // Reset values.
    rst_n = 1'b0; opcode = '0; funct3 = '0; funct7_5 = 1'b0; br_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    #1;
    check("rst.state", state_o, 0);
    check("rst.imem_req", imem_req, 0);
    check("rst.dmem_req", dmem_req, 0);
    check("rst.sext", sext_op, 3'b111);
    check("rst.trap", trap, 0);
    check("rst.strobes", {ir_we, pc_we, rf_we, retire}, 4'b0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("fetch.imem_req", imem_req, 1);

    // FETCH holds its request while the ack is late.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      check("fetch_wait.state", state_o, 0);
      check("fetch_wait.req_ir", {imem_req, ir_we}, 2'b10);
    end

    foreach (vecs[i]) run_vec(vecs[i]);

    // ADDI state trace and sext_op validity window.
    exp_trace = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd0};
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        opcode = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b0; imem_ack = 1'b1;
      end
      if (cyc == 4) imem_ack = 1'b0;
      #1;
      check("addi_trace.state", state_o, exp_trace[cyc]);
      check("addi_trace.sext", sext_op, (cyc == 0 || cyc == 4) ? 3'b111 : 3'b000);
      if (cyc == 3) check("addi_trace.wb_strobes", {rf_we, pc_we, retire}, 3'b111);
    end

    // LW with dmem_ack on the fifth request cycle.
    req_cnt = 0; done = 0;
    for (int cyc = 1; cyc <= 15 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        opcode = 7'b0000011; funct3 = 3'b010; imem_ack = 1'b1; dmem_ack = 1'b0;
      end
      if (dmem_req) req_cnt++;
      dmem_ack = dmem_req && (req_cnt == 5);
      #1;
      if (dmem_req) check("lw_slow.dmem_we", dmem_we, 0);
      if (retire) begin
        check("lw_slow.latency", cyc, 9);
        check("lw_slow.wb", {rf_we, wd_sel}, 3'b101);
        imem_ack = 1'b0;
        done = 1;
      end
    end
    if (!done) check("lw_slow.retired", 0, 1);
    check("lw_slow.req_cycles", req_cnt, 5);
    dmem_ack = 1'b0;

    // Illegal opcode traps after DECODE and ignores later acks.
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin opcode = 7'b0000000; imem_ack = 1'b1; end
      if (cyc == 3) dmem_ack = 1'b1;
      #1;
      if (cyc == 2) check("illegal.decode", state_o, 1);
      if (cyc >= 3) begin
        check("illegal.state", state_o, 7);
        check("illegal.trap", trap, 1);
        check("illegal.quiet", {imem_req, dmem_req, ir_we, pc_we, rf_we, retire}, 6'b0);
      end
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.state", state_o, 0);
    check("async_rst.trap", trap, 0);
    @(negedge clk);
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst_n = 1'b1;

`ifdef MEM_TIMEOUT_EN
    // SW with no dmem_ack times out after five request cycles.
    req_cnt = 0; done = 0;
    for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin opcode = 7'b0100011; funct3 = 3'b010; imem_ack = 1'b1; end
      if (cyc == 2) imem_ack = 1'b0;
      #1;
      if (dmem_req) req_cnt++;
      if (state_o == 3'd7) done = 1;
    end
    check("timeout.reached", done, 1);
    check("timeout.req_cycles", req_cnt, 5);
    check("timeout.dmem_req", dmem_req, 0);
    check("timeout.trap", trap, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
